// File: rtl/batcharger_pkg.sv
// Shared types for the Li-po charge controller: state encoding, default widths
// and the state-to-mode-select decode used by the top level.
package batcharger_pkg;

    localparam int CW_DEF    = 8;
    localparam int TMR_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TC    = 3'd1,
        ST_CC    = 3'd2,
        ST_CV    = 3'd3,
        ST_END   = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    // Returns {tc, cc, cv}; at most one bit is ever set.
    function automatic logic [2:0] sel_decode(input state_e s);
        case (s)
            ST_TC:   sel_decode = 3'b100;
            ST_CC:   sel_decode = 3'b010;
            ST_CV:   sel_decode = 3'b001;
            default: sel_decode = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/batcharger_debounce.sv
// Consecutive-cycle filter for one threshold comparison; with BATCHARGER_DEBOUNCE_EN
// the output asserts only after DEB_CYCLES true cycles, otherwise it passes raw_i through.
module batcharger_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic raw_i,
    output logic ok_o
);

`ifdef BATCHARGER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A single false cycle or any state change restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !raw_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ok_o = raw_i && (cnt_q == CNT_MAX);
`else
    logic unused_deb;
    assign unused_deb = ^{clk, rst, clr_i};
    assign ok_o = raw_i;
`endif

endmodule

// File: rtl/batcharger_controller.sv
// Charge-mode FSM (IDLE/TC/CC/CV/END/FAULT) driving the analogue tc/cc/cv selects
// and ADC monitor enables. Threshold debouncing is enabled by BATCHARGER_DEBOUNCE_EN.
module batcharger_controller
    import batcharger_pkg::*;
#(
    parameter int CW              = CW_DEF,
    parameter int TICK_DIV        = 1000,
    parameter int TMR_W           = TMR_W_DEF,
    parameter int RECHARGE_MARGIN = 8,
    parameter int DEB_CYCLES      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CW-1:0]    vbat,
    input  logic [CW-1:0]    ibat,
    input  logic [CW-1:0]    vtbat,
    input  logic [CW-1:0]    vcutoff,
    input  logic [CW-1:0]    vpreset,
    input  logic [CW-1:0]    iend,
    input  logic [CW-1:0]    tempmin,
    input  logic [CW-1:0]    tempmax,
    input  logic [TMR_W-1:0] tmax,
    output logic             tc,
    output logic             cc,
    output logic             cv,
    output logic             vmonen,
    output logic             imonen,
    output logic             tmonen,
    output logic             done,
    output logic             fault
);

    localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_DIV - 1);
    localparam logic [CW-1:0]    MARGIN   = CW'(RECHARGE_MARGIN);

    state_e           state_q, state_d;
    logic             en_q;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [TMR_W-1:0] tick_q, tick_d;

    logic          temp_ok;
    logic [CW-1:0] rchg_thr;
    logic          chg;
    logic          vcut_ok, vpre_ok, iend_ok, rchg_ok, tlost_ok, tback_ok;

    assign temp_ok  = (vtbat >= tempmin) && (vtbat <= tempmax);
    assign rchg_thr = (vpreset < MARGIN) ? '0 : (vpreset - MARGIN);
    assign chg      = (state_d != state_q);

    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_vcut (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(vbat >= vcutoff), .ok_o(vcut_ok));
    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_vpre (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(vbat >= vpreset), .ok_o(vpre_ok));
    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_iend (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(ibat <= iend), .ok_o(iend_ok));
    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rchg (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(vbat < rchg_thr), .ok_o(rchg_ok));
    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_tlost (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(!temp_ok), .ok_o(tlost_ok));
    batcharger_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_tback (
        .clk(clk), .rst(rst), .clr_i(chg), .raw_i(temp_ok), .ok_o(tback_ok));

    // IDLE qualification uses raw comparisons; only in-charge advances are filtered.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE && tlost_ok) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (temp_ok) begin
                        if (vbat < vcutoff)      state_d = ST_TC;
                        else if (vbat < vpreset) state_d = ST_CC;
                        else                     state_d = ST_END;
                    end
                end
                ST_TC:    if (vcut_ok) state_d = ST_CC;
                ST_CC:    if (vpre_ok) state_d = ST_CV;
                ST_CV:    if (iend_ok || (tick_q >= tmax)) state_d = ST_END;
                ST_END:   if (rchg_ok) state_d = ST_CC;
                ST_FAULT: if (tback_ok) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Timers run only in CV and sit at zero elsewhere, so CV entry always starts from 0.
    always_comb begin
        cyc_d  = cyc_q;
        tick_d = tick_q;
        if (state_q != ST_CV) begin
            cyc_d  = '0;
            tick_d = '0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (tick_q != '1) tick_d = tick_q + 1'b1;
        end else begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            cyc_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
        end
    end

    // en_q keeps tmonen a pure function of registered state, so reset clears it.
    assign {tc, cc, cv} = sel_decode(state_q);
    assign vmonen = (state_q == ST_TC) || (state_q == ST_CC) ||
                    (state_q == ST_CV) || (state_q == ST_END);
    assign imonen = (state_q == ST_CV);
    assign tmonen = (state_q != ST_IDLE) || en_q;
    assign done   = (state_q == ST_END);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_batcharger_controller.sv
// Scoreboarded bench for batcharger_controller: expected output vectors are queued
// with their due cycle when stimulus is applied and compared on the falling edge.
module tb_batcharger_controller;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [7:0]  vbat, ibat, vtbat, vcutoff, vpreset, iend, tempmin, tempmax;
    logic [15:0] tmax;
    logic        tc, cc, cv, vmonen, imonen, tmonen, done, fault;

    batcharger_controller #(
        .CW(8), .TICK_DIV(10), .TMR_W(16), .RECHARGE_MARGIN(8), .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .vbat(vbat), .ibat(ibat), .vtbat(vtbat),
        .vcutoff(vcutoff), .vpreset(vpreset), .iend(iend),
        .tempmin(tempmin), .tempmax(tempmax), .tmax(tmax),
        .tc(tc), .cc(cc), .cv(cv),
        .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Output vector {tc,cc,cv,vmonen,imonen,tmonen,done,fault} per state
    localparam logic [7:0] O_OFF  = 8'h00;
    localparam logic [7:0] O_IDLE = 8'h04;
    localparam logic [7:0] O_TC   = 8'h94;
    localparam logic [7:0] O_CC   = 8'h54;
    localparam logic [7:0] O_CV   = 8'h3C;
    localparam logic [7:0] O_END  = 8'h16;
    localparam logic [7:0] O_FLT  = 8'h05;

    typedef struct {
        int         cyc;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_total = 0;
    int   n_bad   = 0;

    wire [7:0] obs = {tc, cc, cv, vmonen, imonen, tmonen, done, fault};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%02h want=%02h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    task automatic expect_o(input string tag, input int dly, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc_cnt + dly;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc_cnt) begin
                chk(sb[i].tag, obs, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1;
        vcutoff = 8'h60; vpreset = 8'hC0; iend = 8'h10;
        tempmin = 8'h20; tempmax = 8'hE0; vtbat = 8'h80;
        vbat = 8'h40; ibat = 8'h50; tmax = 16'hFFFF;
        step(2);
        expect_o("reset", 0, O_OFF);
        rst = 1'b0;
        expect_o("idle_to_tc", 1, O_TC);
        step(1);

`ifdef BATCHARGER_DEBOUNCE_EN
        vbat = 8'h60;
        expect_o("deb_pulse1", 1, O_TC);
        expect_o("deb_pulse2", 2, O_TC);
        expect_o("deb_pulse3", 3, O_TC);
        step(3);
        vbat = 8'h40;
        expect_o("deb_gap", 1, O_TC);
        step(1);
        vbat = 8'h60;
        expect_o("deb_hold4", 4, O_TC);
        expect_o("deb_cc5", 5, O_CC);
        step(5);
`else
        vbat = 8'h5F; expect_o("tc_hold", 1, O_TC);  step(1);
        vbat = 8'h60; expect_o("tc_to_cc", 1, O_CC); step(1);
        vbat = 8'hBF; expect_o("cc_hold", 1, O_CC);  step(1);
        vbat = 8'hC0; expect_o("cc_to_cv", 1, O_CV); step(1);
        ibat = 8'h11; expect_o("cv_hold", 1, O_CV);  step(1);
        ibat = 8'h10; expect_o("cv_to_end", 1, O_END); step(1);

        // Recharge threshold is 0xC0 - 8 = 0xB8, strictly below
        vbat = 8'hB9; expect_o("end_b9", 1, O_END);  step(1);
        vbat = 8'hB8; expect_o("end_b8", 1, O_END);  step(1);
        vbat = 8'hB7; expect_o("recharge", 1, O_CC); step(1);

        vtbat = 8'hE0; expect_o("temp_edge_hi", 1, O_CC); step(1);
        vtbat = 8'hF0; expect_o("fault_hi", 1, O_FLT);    step(1);
        vtbat = 8'h80;
        expect_o("fault_idle", 1, O_IDLE);
        expect_o("fault_requal", 2, O_CC);
        step(2);
        vtbat = 8'h1F; expect_o("fault_lo", 1, O_FLT); step(1);
        vtbat = 8'h20;
        expect_o("lo_idle", 1, O_IDLE);
        expect_o("lo_requal", 2, O_CC);
        step(2);

        // CV timeout: 3 ticks of 10 cycles; condition seen in CV cycle 30
        ibat = 8'h50; tmax = 16'd3; vbat = 8'hC0;
        expect_o("to_cv_entry", 1, O_CV);
        step(1);
        expect_o("to_hold29", 29, O_CV);
        expect_o("to_hold30", 30, O_CV);
        expect_o("to_end", 31, O_END);
        step(31);

        tmax = 16'd0; vbat = 8'hB0;
        expect_o("t0_cc", 1, O_CC);
        step(1);
        vbat = 8'hC0;
        expect_o("t0_cv", 1, O_CV);
        expect_o("t0_end", 2, O_END);
        step(2);

        tmax = 16'hFFFF; vbat = 8'hB0; expect_o("dis_cc", 1, O_CC); step(1);
        vbat = 8'hC0; expect_o("dis_cv", 1, O_CV); step(1);
        en = 1'b0; expect_o("dis_idle", 1, O_OFF); step(1);
        en = 1'b1; expect_o("reen_end", 1, O_END); step(1);

        vbat = 8'hB0; expect_o("rst_cc", 1, O_CC); step(1);
        rst = 1'b1; expect_o("rst_off", 1, O_OFF); step(1);
        rst = 1'b0; expect_o("rst_requal", 1, O_CC); step(1);

        // vpreset below the margin: recharge threshold saturates at zero
        vpreset = 8'h05; expect_o("sat_cv", 1, O_CV); step(1);
        ibat = 8'h10; expect_o("sat_end", 1, O_END); step(1);
        vbat = 8'h00;
        expect_o("sat_hold1", 1, O_END);
        expect_o("sat_hold2", 2, O_END);
        step(2);
`endif

        for (int g = 0; g < 50 && sb.size() > 0; g++) step(1);
        if (sb.size() > 0) chk("sb_drain", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
